// File: rtl/dieu_che_xung.sv
// PWM pulse shaper: picks one tao_xung divided clock as a rate tick, resynchronises it,
// and drives a double-buffered programmable period/duty PWM waveform.
module dieu_che_xung #(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clki,
  input  logic             rst,
  input  logic [2:0]       clko_in,
  input  logic [1:0]       sel,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] duty,
  input  logic             load,
  output logic             tick_o,
  output logic             pwm_o,
  output logic             cycle_done,
  output logic             pending_o
);

  typedef enum logic {StIdle, StRun} state_e;

  logic [2:0]       sync_q [SYNC_STAGES];
  logic [2:0]       hist_q;
  logic [2:0]       rise;
  logic             tick_d, tick_q;

  state_e           state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic [CNT_W-1:0] period_a_d, period_a_q, duty_a_d, duty_a_q;
  logic [CNT_W-1:0] period_s_d, period_s_q, duty_s_d, duty_s_q;
  logic             pending_d, pending_q;
  logic             cycle_done_d, cycle_done_q;
  logic             wrap;

  // Detectors run on all three bits so switching sel never exposes a stale edge.
  assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;

  always_comb begin
    tick_d = 1'b0;
    unique case (sel)
      2'd0:    tick_d = rise[0];
      2'd1:    tick_d = rise[1];
      2'd2:    tick_d = rise[2];
      default: tick_d = 1'b1;
    endcase
  end

  assign wrap = tick_q && (cnt_q == (period_a_q - CNT_W'(1)));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    period_a_d   = period_a_q;
    duty_a_d     = duty_a_q;
    period_s_d   = period_s_q;
    duty_s_d     = duty_s_q;
    pending_d    = pending_q;
    cycle_done_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (load && (period != '0)) begin
          period_a_d = period;
          duty_a_d   = duty;
          state_d    = StRun;
        end
      end
      StRun: begin
        if (wrap) begin
          cnt_d        = '0;
          cycle_done_d = 1'b1;
          // A load coinciding with the wrap takes effect right here and supersedes the shadow.
          if (load) begin
            period_a_d = period;
            duty_a_d   = duty;
            pending_d  = 1'b0;
            if (period == '0) state_d = StIdle;
          end else if (pending_q) begin
            period_a_d = period_s_q;
            duty_a_d   = duty_s_q;
            pending_d  = 1'b0;
            if (period_s_q == '0) state_d = StIdle;
          end
        end else begin
          if (tick_q) cnt_d = cnt_q + CNT_W'(1);
          if (load) begin
            period_s_d = period;
            duty_s_d   = duty;
            pending_d  = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clki) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      hist_q       <= '0;
      tick_q       <= 1'b0;
      state_q      <= StIdle;
      cnt_q        <= '0;
      period_a_q   <= '0;
      duty_a_q     <= '0;
      period_s_q   <= '0;
      duty_s_q     <= '0;
      pending_q    <= 1'b0;
      cycle_done_q <= 1'b0;
    end else begin
      sync_q[0] <= clko_in;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      hist_q       <= sync_q[SYNC_STAGES-1];
      tick_q       <= tick_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      period_a_q   <= period_a_d;
      duty_a_q     <= duty_a_d;
      period_s_q   <= period_s_d;
      duty_s_q     <= duty_s_d;
      pending_q    <= pending_d;
      cycle_done_q <= cycle_done_d;
    end
  end

  assign tick_o     = tick_q;
  assign pwm_o      = (state_q == StRun) && (cnt_q < duty_a_q);
  assign cycle_done = cycle_done_q;
  assign pending_o  = pending_q;

endmodule
